// File: rtl/dpu_seq_pkg.sv
// rtl/dpu_seq_pkg.sv - shared encodings for the dpu microprogram sequencer
package dpu_seq_pkg;

    localparam int WORD_W = 18;

    // Instruction classes, word[17:16]
    localparam logic [1:0] CLS_ALU    = 2'b00;
    localparam logic [1:0] CLS_BRANCH = 2'b01;
    localparam logic [1:0] CLS_EMIT   = 2'b10;
    localparam logic [1:0] CLS_HALT   = 2'b11;

    // Field positions
    localparam int CLS_HI    = 17;
    localparam int CLS_LO    = 16;
    localparam int N_HI      = 14;
    localparam int N_LO      = 12;
    localparam int R_HI      = 11;
    localparam int R_LO      = 8;
    localparam int A_HI      = 7;
    localparam int A_LO      = 4;
    localparam int B_HI      = 3;
    localparam int B_LO      = 0;
    localparam int BR_ALWAYS = 15;
    localparam int BR_POL    = 14;
    localparam int BR_SEL_HI = 13;
    localparam int BR_SEL_LO = 12;

    // Condition-code bit selected by a branch's sel field
    localparam logic [1:0] CC_SEL_0 = 2'd0;
    localparam logic [1:0] CC_SEL_1 = 2'd1;
    localparam logic [1:0] CC_SEL_2 = 2'd2;
    localparam logic [1:0] CC_SEL_3 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_SETTLE,
        ST_EXEC,
        ST_FINISH
    } state_t;

    function automatic logic [1:0] word_class(input logic [WORD_W-1:0] w);
        return w[CLS_HI:CLS_LO];
    endfunction

endpackage

// File: rtl/dpu_prog_ram.sv
// rtl/dpu_prog_ram.sv - microprogram store, single write port, synchronous read
module dpu_prog_ram
    import dpu_seq_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PC_W-1:0]   waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [PC_W-1:0]   raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**PC_W];

    // Write and registered read; rdata holds while re is low
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dpu_sequencer.sv
// rtl/dpu_sequencer.sv - microprogram sequencer driving the DPU buses and opcode
module dpu_sequencer
    import dpu_seq_pkg::*;
#(
    parameter int PC_W      = 8,
    parameter int MAX_STEPS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [WORD_W-1:0] prog_wdata,
    input  logic              start,
    input  logic [PC_W-1:0]   start_pc,
    input  logic [3:0]        cc,
    output logic [3:0]        Abus,
    output logic [3:0]        Bbus,
    output logic [3:0]        Rbus,
    output logic [2:0]        n,
    output logic              alu_stb,
    output logic              k_valid,
    output logic              busy,
    output logic              done,
    output logic              abort,
    output logic [PC_W-1:0]   pc
);

    localparam int STEP_W = $clog2(MAX_STEPS + 1);

    state_t            state;
    state_t            state_nx;
    state_t            cur;
    logic [PC_W-1:0]   pc_nx;
    logic [STEP_W-1:0] steps;
    logic [STEP_W-1:0] steps_nx;
    logic [3:0]        cc_q;
    logic [3:0]        cc_nx;
    logic [3:0]        a_q;
    logic [3:0]        b_q;
    logic [3:0]        r_q;
    logic [2:0]        n_q;
    logic              load_bus;
    logic              ram_we;
    logic              ram_re;
    logic              taken;
    logic [WORD_W-1:0] word;

    // Program writes are only accepted while idle so a running kernel is never altered
    assign ram_we = prog_we && (state == ST_IDLE);

    dpu_prog_ram #(
        .PC_W(PC_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .re    (ram_re),
        .raddr (pc),
        .rdata (word)
    );

    // The word's class is only known the cycle after FETCH, so that cycle resolves to ISSUE or EXEC
    always_comb begin
        cur = state;
        if ((state == ST_ISSUE) && (word_class(word) != CLS_ALU)) begin
            cur = ST_EXEC;
        end
    end

    assign taken = word[BR_ALWAYS] || (cc_q[word[BR_SEL_HI:BR_SEL_LO]] == word[BR_POL]);

    // Next-state, counters and strobes
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        steps_nx = steps;
        cc_nx    = cc_q;
        ram_re   = 1'b0;
        load_bus = 1'b0;
        alu_stb  = 1'b0;
        k_valid  = 1'b0;
        done     = 1'b0;
        abort    = 1'b0;
        case (cur)
            ST_IDLE: begin
                if (start) begin
                    pc_nx    = start_pc;
                    steps_nx = '0;
                    state_nx = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (steps == STEP_W'(MAX_STEPS)) begin
                    abort    = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    ram_re   = 1'b1;
                    steps_nx = steps + 1'b1;
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                alu_stb  = 1'b1;
                load_bus = 1'b1;
                state_nx = ST_SETTLE;
            end
            ST_SETTLE: begin
                cc_nx    = cc;
                pc_nx    = pc + 1'b1;
                state_nx = ST_FETCH;
            end
            ST_EXEC: begin
                state_nx = ST_FETCH;
                case (word_class(word))
                    CLS_BRANCH: pc_nx = taken ? word[PC_W-1:0] : pc + 1'b1;
                    CLS_EMIT: begin
                        k_valid = 1'b1;
                        pc_nx   = pc + 1'b1;
                    end
                    CLS_HALT: state_nx = ST_FINISH;
                    default:  pc_nx = pc + 1'b1;
                endcase
            end
            ST_FINISH: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State, pc, step counter, captured cc and held bus values
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            pc    <= '0;
            steps <= '0;
            cc_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
            n_q   <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            steps <= steps_nx;
            cc_q  <= cc_nx;
            if (load_bus) begin
                a_q <= word[A_HI:A_LO];
                b_q <= word[B_HI:B_LO];
                r_q <= word[R_HI:R_LO];
                n_q <= word[N_HI:N_LO];
            end
        end
    end

    // Buses show the fresh word during ISSUE and otherwise hold the last ALU values
    assign Abus = (cur == ST_ISSUE) ? word[A_HI:A_LO] : a_q;
    assign Bbus = (cur == ST_ISSUE) ? word[B_HI:B_LO] : b_q;
    assign Rbus = (cur == ST_ISSUE) ? word[R_HI:R_LO] : r_q;
    assign n    = (cur == ST_ISSUE) ? word[N_HI:N_LO] : n_q;
    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_dpu_sequencer.sv
// tb/tb_dpu_sequencer.sv - scoreboard bench for dpu_sequencer
module tb_dpu_sequencer;

    localparam int PC_W = 8;
    localparam int K_ALU = 0, K_KV = 1, K_DONE = 2, K_ABORT = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            prog_we = 1'b0;
    logic [PC_W-1:0] prog_addr = '0;
    logic [17:0]     prog_wdata = '0;
    logic            start = 1'b0;
    logic [PC_W-1:0] start_pc = '0;
    logic [3:0]      cc = '0;
    logic [3:0]      Abus, Bbus, Rbus;
    logic [2:0]      n;
    logic            alu_stb, k_valid, busy, done, abort;
    logic [PC_W-1:0] pc;

    typedef struct {
        int kind;
        int rel;
        int pc;
        int a;
        int b;
        int r;
        int n;
    } ev_t;

    ev_t expq[$];
    int  cyc = 0;
    int  t0 = 0;
    int  nchk = 0;
    int  nfail = 0;

    dpu_sequencer #(.PC_W(PC_W), .MAX_STEPS(16)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .start(start), .start_pc(start_pc), .cc(cc),
        .Abus(Abus), .Bbus(Bbus), .Rbus(Rbus), .n(n), .alu_stb(alu_stb),
        .k_valid(k_valid), .busy(busy), .done(done), .abort(abort), .pc(pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [17:0] w_alu(input int nn, input int r, input int a, input int b);
        return {2'b00, 1'b0, 3'(nn), 4'(r), 4'(a), 4'(b)};
    endfunction
    function automatic logic [17:0] w_br(input int alw, input int pol, input int sel, input int tgt);
        return {2'b01, 1'(alw), 1'(pol), 2'(sel), 4'b0, 8'(tgt)};
    endfunction
    localparam logic [17:0] W_EMIT = {2'b10, 16'b0};
    localparam logic [17:0] W_HALT = {2'b11, 16'b0};

    task automatic push(input int kind, input int rel, input int p,
                        input int a, input int b, input int r, input int nn);
        ev_t e;
        e.kind = kind; e.rel = rel; e.pc = p; e.a = a; e.b = b; e.r = r; e.n = nn;
        expq.push_back(e);
    endtask

    task automatic load(input int addr, input logic [17:0] data);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 8'(addr); prog_wdata = data;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic do_start(input int spc);
        @(negedge clk);
        start = 1'b1; start_pc = 8'(spc); t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((busy || expq.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({name, "_busy_end"}, int'(busy), 0);
        check({name, "_events_left"}, expq.size(), 0);
    endtask

    // Monitor: pops one expected event whenever the DUT strobes an output
    always @(negedge clk) begin
        if (!rst && (alu_stb || k_valid || done || abort)) begin
            int kind;
            ev_t e;
            kind = alu_stb ? K_ALU : (k_valid ? K_KV : (done ? K_DONE : K_ABORT));
            if (done || abort) check("done_abort_excl", int'(done && abort), 0);
            if (expq.size() == 0) begin
                check("unexpected_event_kind", kind, -1);
            end else begin
                e = expq.pop_front();
                check("ev_kind", kind, e.kind);
                check("ev_cycle", cyc - t0, e.rel);
                check("ev_pc", int'(pc), e.pc);
                if (e.kind == K_ALU) begin
                    check("ev_abus", int'(Abus), e.a);
                    check("ev_bbus", int'(Bbus), e.b);
                    check("ev_rbus", int'(Rbus), e.r);
                    check("ev_n", int'(n), e.n);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_abus", int'(Abus), 0);
        check("rst_rbus", int'(Rbus), 0);
        check("rst_stb", int'(alu_stb | k_valid | done | abort), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pc", int'(pc), 0);

        // ALU then HALT
        load(0, w_alu(0, 9, 1, 2));
        load(1, W_HALT);
        push(K_ALU, 2, 0, 1, 2, 9, 0);
        push(K_DONE, 6, 1, 0, 0, 0, 0);
        do_start(0);
        check("busy_after_start", int'(busy), 1);
        wait_idle("t1");
        check("t1_hold_abus", int'(Abus), 1);
        check("t1_hold_rbus", int'(Rbus), 9);

        // Unconditional branch 0 -> 5
        load(0, w_br(1, 0, 0, 5));
        load(5, W_HALT);
        push(K_DONE, 5, 5, 0, 0, 0, 0);
        do_start(0);
        wait_idle("t2");

        // Conditional branch on cc[2], taken then not taken
        load(16, w_alu(3, 4, 5, 6));
        load(17, w_br(0, 1, 2, 32));
        load(18, W_HALT);
        load(32, W_HALT);
        cc = 4'b0100;
        push(K_ALU, 2, 16, 5, 6, 4, 3);
        push(K_DONE, 8, 32, 0, 0, 0, 0);
        do_start(16);
        wait_idle("t3_taken");
        cc = 4'b0000;
        push(K_ALU, 2, 16, 5, 6, 4, 3);
        push(K_DONE, 8, 18, 0, 0, 0, 0);
        do_start(16);
        wait_idle("t3_fall");

        // Self-loop runs into the step limit
        load(48, w_br(1, 0, 0, 48));
        push(K_ABORT, 33, 48, 0, 0, 0, 0);
        do_start(48);
        wait_idle("t4");

        // Reset during SETTLE, then rerun with start/prog_we while busy
        cc = 4'b0100;
        push(K_ALU, 2, 16, 5, 6, 4, 3);
        do_start(16);
        @(negedge clk);
        @(negedge clk);
        check("settle_hold_abus", int'(Abus), 5);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_abus", int'(Abus), 0);
        check("midrst_bbus", int'(Bbus), 0);
        check("midrst_n", int'(n), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_pc", int'(pc), 0);
        rst = 1'b0;
        check("midrst_events_left", expq.size(), 0);
        push(K_ALU, 2, 16, 5, 6, 4, 3);
        push(K_DONE, 8, 32, 0, 0, 0, 0);
        do_start(16);
        prog_we = 1'b1; prog_addr = 8'd32; prog_wdata = W_EMIT;
        start = 1'b1; start_pc = 8'd18;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        wait_idle("t6");

        // Same-cycle write and start at 0xFF, EMIT then wrap to HALT at 0x00
        load(255, W_HALT);
        load(0, W_HALT);
        push(K_KV, 2, 255, 0, 0, 0, 0);
        push(K_DONE, 5, 0, 0, 0, 0, 0);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 8'd255; prog_wdata = W_EMIT;
        start = 1'b1; start_pc = 8'd255; t0 = cyc;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        wait_idle("t5");

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
